// File: rtl/ddr_axi_pattern_tester.sv
// AXI4 master that writes a deterministic pattern over a DDR region, reads it back and scores every beat.
// Define DDR_TESTER_PRBS_EN to replace the address-based pattern with a PRBS-31 data stream.
module ddr_axi_pattern_tester #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int ERR_W      = 16
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,

  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,

  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,

  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int LANES = DATA_W / 32;
  localparam int SIZE  = $clog2(BYTES);
  localparam int BTW   = $clog2(BURST_LEN + 1);
  localparam int BCW   = $clog2(NUM_BURSTS + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_FIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] burst_addr;
  logic [BTW-1:0]    beat_cnt;
  logic [BCW-1:0]    burst_cnt;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] first_q;
  logic              pass_q;
  logic [DATA_W-1:0] expected;
  logic              beat_last, burst_last;
  logic              err_hit;
  logic [ADDR_W-1:0] err_at;

  assign beat_last  = (beat_cnt == BTW'(BURST_LEN - 1));
  assign burst_last = (burst_cnt == BCW'(NUM_BURSTS - 1));

`ifdef DDR_TESTER_PRBS_EN
  logic [30:0] lfsr, lfsr_next, prbs_state;

  // One beat consumes DATA_W successive LFSR output bits, first bit in bit 0.
  always_comb begin
    prbs_state = lfsr;
    expected   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      prbs_state  = {prbs_state[29:0], prbs_state[30] ^ prbs_state[27]};
      expected[i] = prbs_state[0];
    end
    lfsr_next = prbs_state;
  end

  always_ff @(posedge aclk) begin
    if (rst)
      lfsr <= 31'h1;
    else if ((state == S_IDLE && start) || (state == S_WB && m_axi_bvalid && burst_last))
      lfsr <= 31'h1;
    else if ((state == S_WD && m_axi_wready) || (state == S_RD && m_axi_rvalid))
      lfsr <= lfsr_next;
  end
`else
  always_comb begin
    expected = '0;
    for (int i = 0; i < LANES; i++)
      expected[i*32 +: 32] = cur_addr[31:0] ^ 32'(i);
  end
`endif

  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = expected;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = beat_last;
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;

  assign busy           = (state inside {S_WA, S_WD, S_WB, S_RA, S_RD});
  assign done           = (state == S_FIN);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;

  always_ff @(posedge aclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Burst sequencing; only one AXI transaction is ever in flight.
  always_comb begin
    state_next    = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_WA;
      S_WA: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = S_WD;
      end
      S_WD: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && beat_last) state_next = S_WB;
      end
      S_WB: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = burst_last ? S_RA : S_WA;
      end
      S_RA: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = S_RD;
      end
      S_RD: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && beat_last) state_next = burst_last ? S_FIN : S_RA;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bad write responses are charged to the burst; read faults to the beat.
  always_comb begin
    err_hit = 1'b0;
    err_at  = cur_addr;
    if (state == S_WB && m_axi_bvalid && m_axi_bresp != 2'b00) begin
      err_hit = 1'b1;
      err_at  = burst_addr;
    end
    if (state == S_RD && m_axi_rvalid &&
        (m_axi_rdata != expected || m_axi_rresp != 2'b00 || m_axi_rlast != beat_last))
      err_hit = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cur_addr   <= '0;
      burst_addr <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      if (err_hit && err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
      if (err_hit && err_cnt_q == '0)      first_q   <= err_at;
      case (state)
        S_IDLE: if (start) begin
          cur_addr  <= BASE_ADDR;
          beat_cnt  <= '0;
          burst_cnt <= '0;
          err_cnt_q <= '0;
          first_q   <= '0;
          pass_q    <= 1'b0;
        end
        S_WA: if (m_axi_awready) burst_addr <= cur_addr;
        S_WD: if (m_axi_wready) begin
          cur_addr <= cur_addr + ADDR_W'(BYTES);
          beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        end
        S_WB: if (m_axi_bvalid) begin
          if (burst_last) begin
            burst_cnt <= '0;
            cur_addr  <= BASE_ADDR;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        S_RD: if (m_axi_rvalid) begin
          cur_addr <= cur_addr + ADDR_W'(BYTES);
          beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
          if (beat_last) burst_cnt <= burst_last ? '0 : burst_cnt + 1'b1;
        end
        S_FIN: pass_q <= (err_cnt_q == '0);
        default: ;
      endcase
    end
  end

endmodule
